output_reg_fifo: RTL and testbench
==================================

OUTPUT_REG_FIFO -- requirements
Module: output_reg_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 256, the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the number of stored words; it must be a power of two and at least 2.
REQ-003 SHALL derive CNT_W = log2(DEPTH)+1 internally; CNT_W is not user-settable.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 write_data  in  1  push request, sampled at the rising edge of clk.
REQ-007 data_to_write  in  WIDTH  word to push.
REQ-008 read_data  in  1  pop request, sampled at the rising edge of clk.
REQ-009 clear_flags  in  1  synchronous clear of the sticky error flags.
REQ-010 data  out  WIDTH  head-of-queue word; all zeros when the queue is empty.
REQ-011 data_valid  out  1  high when count != 0.
REQ-012 full  out  1  high when count == DEPTH.
REQ-013 count  out  CNT_W  number of stored words, range 0..DEPTH.
REQ-014 overflow  out  1  sticky flag; set by a rejected push.
REQ-015 underflow  out  1  sticky flag; set by a rejected pop.

Function
REQ-016 SHALL implement a circular buffer of DEPTH x WIDTH storage with a write pointer and a read pointer, each log2(DEPTH) bits wide.
REQ-017 A push SHALL be accepted when write_data=1 and either full=0 or a pop is accepted in the same cycle; an accepted push stores the word at the write pointer and advances the pointer.
REQ-018 A pop SHALL be accepted when read_data=1 and count != 0; an accepted pop advances the read pointer.
REQ-019 Both pointers SHALL wrap from DEPTH-1 to 0 with no gap or stall.
REQ-020 count SHALL change by +1 (push only), -1 (pop only) or 0 (both or neither), and SHALL never leave the range 0..DEPTH.
REQ-021 data SHALL be a combinational view of the storage at the read pointer, gated to zero when the queue is empty; there are no registered output stages.
REQ-022 A word pushed into an empty queue SHALL appear on data, with data_valid=1, immediately after that clock edge, i.e. zero added cycles of latency.
REQ-023 Push and pop in the same cycle while full SHALL both be accepted; count stays DEPTH and data advances to the next word.
REQ-024 Push and pop in the same cycle while empty: the push SHALL be accepted, the pop rejected, underflow set, and count becomes 1.
REQ-025 A push while full with no pop SHALL be dropped, leave storage unchanged and set overflow.
REQ-026 A pop while empty SHALL leave the pointers unchanged and set underflow.
REQ-027 clear_flags=1 SHALL clear overflow and underflow at the next clock edge; a new error event in the same cycle takes priority and sets its flag.
REQ-028 The contents of data_to_write SHALL be ignored whenever no push is accepted.

Reset
REQ-029 reset=0 SHALL immediately, without waiting for a clock edge, force both pointers, count, overflow and underflow to 0.
REQ-030 While reset=0: data=0, data_valid=0 and full=0; storage contents are don't-care and never visible.
REQ-031 Reset asserted mid-operation SHALL discard all queued words; the first push after reset is released is stored at location 0.
REQ-032 Release of reset SHALL be synchronised by the system; the block adds no reset synchroniser.

Verification
REQ-033 Reset then push 0x5555555 -> next cycle: data=0x5555555, data_valid=1, count=1, full=0.
REQ-034 DEPTH=4: push A,B,C,D on consecutive cycles -> full=1, count=4; a fifth push E -> overflow=1, and pops return A,B,C,D in order, then data_valid=0 and data=0.
REQ-035 Full queue, push and pop in the same cycle -> count stays 4, overflow=0, data steps A->B, and E is later read fourth after B,C,D.
REQ-036 Empty queue, pop -> underflow=1, count=0; then clear_flags=1 for one cycle -> underflow=0; clear_flags plus pop on empty in the same cycle -> underflow stays 1.
REQ-037 Push 10 words interleaved with 10 pops while count stays <= 2 -> data matches push order across pointer wrap, with no flags set.
REQ-038 Push 3 words, assert reset low for 4 ns between clock edges -> count=0 and data_valid=0 immediately; after release, push 0xAAAAAAA -> data=0xAAAAAAA, count=1.

Source files
------------

// File: rtl/output_reg_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : output_reg_fifo_if
//  Description : Handshake/data bundle for output_reg_fifo.
//                master : producer/consumer side (drives push/pop requests)
//                slave  : FIFO side (returns head word, status and flags)
//                Signals:
//                  write_data    push request
//                  data_to_write word to push
//                  read_data     pop request
//                  clear_flags   synchronous clear of sticky error flags
//                  data          head-of-queue word, zero when empty
//                  data_valid    queue not empty
//                  full          queue holds DEPTH words
//                  count         number of stored words (0..DEPTH)
//                  overflow      sticky, set by a rejected push
//                  underflow     sticky, set by a rejected pop
//  Revision    : 1.0  initial release
// ============================================================================
interface output_reg_fifo_if #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             write_data;
    logic [WIDTH-1:0] data_to_write;
    logic             read_data;
    logic             clear_flags;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_data,
        output data_to_write,
        output read_data,
        output clear_flags,
        input  data,
        input  data_valid,
        input  full,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  write_data,
        input  data_to_write,
        input  read_data,
        input  clear_flags,
        output data,
        output data_valid,
        output full,
        output count,
        output overflow,
        output underflow
    );
endinterface
`default_nettype wire

// File: rtl/output_reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : output_reg_fifo
//  Description : Circular-buffer FIFO of DEPTH x WIDTH words whose head word
//                is presented combinationally (no registered output stage):
//                a word pushed into an empty queue is visible right after
//                the clock edge that stored it.
//                Ports:
//                  clk    single clock, rising-edge active
//                  reset  asynchronous, active-low reset
//                  bus    output_reg_fifo_if.slave (push/pop/status/flags)
//                DEPTH must be a power of two and at least 2.
//  Revision    : 1.0  initial release
// ============================================================================
module output_reg_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    output_reg_fifo_if.slave      bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    // ------------------------------------------------------------------
    // Accept logic
    // ------------------------------------------------------------------
    logic w_not_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_push_rej;
    logic w_pop_rej;

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == c_cnt_full);

    // A pop frees a slot in the same cycle, so a push into a full queue is
    // still accepted when it is paired with an accepted pop.
    assign w_pop_ok   = bus.read_data  & w_not_empty;
    assign w_push_ok  = bus.write_data & (~w_full | w_pop_ok);
    assign w_push_rej = bus.write_data & ~w_push_ok;
    assign w_pop_rej  = bus.read_data  & ~w_pop_ok;

    // ------------------------------------------------------------------
    // Next-state for count and sticky flags
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_overflow_nxt;
    logic             w_underflow_nxt;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // A fresh error event outranks clear_flags in the same cycle.
    always_comb begin
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        if (bus.clear_flags) begin
            w_overflow_nxt  = 1'b0;
            w_underflow_nxt = 1'b0;
        end
        if (w_push_rej) begin
            w_overflow_nxt = 1'b1;
        end
        if (w_pop_rej) begin
            w_underflow_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers (asynchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Power-of-two depth: natural pointer overflow is the wrap.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count     <= w_count_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset needed, an empty queue never exposes its contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.data_to_write;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // count is forced to zero by reset, so gating on it also blanks the
    // head word and status while reset is held.
    assign bus.data       = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign bus.data_valid = w_not_empty;
    assign bus.full       = w_full;
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_output_reg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_reg_fifo
//  Description : Directed self-checking bench for output_reg_fifo
//                (WIDTH=256, DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_output_reg_fifo;

    localparam int WIDTH = 256;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [WIDTH-1:0] c_w_a = 256'hA0A0_0001;
    localparam logic [WIDTH-1:0] c_w_b = 256'hB0B0_0002;
    localparam logic [WIDTH-1:0] c_w_c = 256'hC0C0_0003;
    localparam logic [WIDTH-1:0] c_w_d = 256'hD0D0_0004;
    localparam logic [WIDTH-1:0] c_w_e = 256'hE0E0_0005;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    output_reg_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    output_reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_data    = 1'b0;
        bus.read_data     = 1'b0;
        bus.clear_flags   = 1'b0;
        bus.data_to_write = '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        bus.write_data    = 1'b1;
        bus.data_to_write = w;
        tick();
        idle_inputs();
    endtask

    task automatic pop();
        bus.read_data = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic clear();
        bus.clear_flags = 1'b1;
        tick();
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        total++; if (bus.count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        total++; if (bus.data_valid !== 1'b0 || bus.full !== 1'b0) begin bad++; $display("FAIL reset_status: valid=%b full=%b want 0 0", bus.data_valid, bus.full); end
        total++; if (bus.data !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.data); end
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_flags: ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_first_push();
        push(256'h5555555);
        total++; if (bus.data !== 256'h5555555) begin bad++; $display("FAIL first_push_data: got %h want 5555555", bus.data); end
        total++; if (bus.data_valid !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL first_push_status: valid=%b full=%b want 1 0", bus.data_valid, bus.full); end
        total++; if (bus.count !== CNT_W'(1)) begin bad++; $display("FAIL first_push_count: got %0d want 1", bus.count); end
        pop();
        total++; if (bus.count !== '0 || bus.data !== '0) begin bad++; $display("FAIL first_push_drain: count=%0d data=%h want 0 0", bus.count, bus.data); end
    endtask

    task automatic test_fill_overflow();
        logic [WIDTH-1:0] exp_q [4];
        exp_q = '{c_w_a, c_w_b, c_w_c, c_w_d};
        push(c_w_a); push(c_w_b); push(c_w_c); push(c_w_d);
        total++; if (bus.full !== 1'b1 || bus.count !== CNT_W'(4)) begin bad++; $display("FAIL fill_full: full=%b count=%0d want 1 4", bus.full, bus.count); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf: got %b want 0", bus.overflow); end
        push(c_w_e);
        total++; if (bus.overflow !== 1'b1 || bus.count !== CNT_W'(4)) begin bad++; $display("FAIL ovf_set: ovf=%b count=%0d want 1 4", bus.overflow, bus.count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.data !== exp_q[i]) begin bad++; $display("FAIL ovf_pop_order[%0d]: got %h want %h", i, bus.data, exp_q[i]); end
            pop();
        end
        total++; if (bus.data_valid !== 1'b0 || bus.data !== '0) begin bad++; $display("FAIL ovf_empty: valid=%b data=%h want 0 0", bus.data_valid, bus.data); end
        clear();
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] exp_q [4];
        exp_q = '{c_w_b, c_w_c, c_w_d, c_w_e};
        push(c_w_a); push(c_w_b); push(c_w_c); push(c_w_d);
        bus.write_data    = 1'b1;
        bus.data_to_write = c_w_e;
        bus.read_data     = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.count !== CNT_W'(4) || bus.overflow !== 1'b0) begin bad++; $display("FAIL fullpp_count: count=%0d ovf=%b want 4 0", bus.count, bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.data !== exp_q[i]) begin bad++; $display("FAIL fullpp_order[%0d]: got %h want %h", i, bus.data, exp_q[i]); end
            pop();
        end
        total++; if (bus.count !== '0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL fullpp_end: count=%0d unf=%b want 0 0", bus.count, bus.underflow); end
    endtask

    task automatic test_underflow();
        pop();
        total++; if (bus.underflow !== 1'b1 || bus.count !== '0) begin bad++; $display("FAIL unf_set: unf=%b count=%0d want 1 0", bus.underflow, bus.count); end
        clear();
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL unf_clear: got %b want 0", bus.underflow); end
        pop();
        bus.clear_flags = 1'b1;
        bus.read_data   = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_priority: got %b want 1", bus.underflow); end
        clear();
        // push + pop on an empty queue: push wins, pop is rejected
        bus.write_data    = 1'b1;
        bus.data_to_write = c_w_c;
        bus.read_data     = 1'b1;
        tick();
        idle_inputs();
        total++; if (bus.count !== CNT_W'(1) || bus.underflow !== 1'b1 || bus.data !== c_w_c) begin bad++; $display("FAIL emptypp: count=%0d unf=%b data=%h want 1 1 %h", bus.count, bus.underflow, bus.data, c_w_c); end
        pop();
        clear();
        total++; if (bus.count !== '0 || bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL unf_end: count=%0d unf=%b ovf=%b want 0 0 0", bus.count, bus.underflow, bus.overflow); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] w;
        push(256'h100);
        for (int i = 0; i < 9; i++) begin
            w = 256'h100 + WIDTH'(i);
            total++; if (bus.data !== w || bus.count !== CNT_W'(1)) begin bad++; $display("FAIL wrap[%0d]: data=%h count=%0d want %h 1", i, bus.data, bus.count, w); end
            bus.write_data    = 1'b1;
            bus.data_to_write = 256'h100 + WIDTH'(i + 1);
            bus.read_data     = 1'b1;
            tick();
            idle_inputs();
        end
        total++; if (bus.data !== 256'h109) begin bad++; $display("FAIL wrap_last: got %h want 109", bus.data); end
        pop();
        total++; if (bus.count !== '0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL wrap_flags: count=%0d ovf=%b unf=%b want 0 0 0", bus.count, bus.overflow, bus.underflow); end
    endtask

    task automatic test_mid_reset();
        push(c_w_a); push(c_w_b); push(c_w_c);
        total++; if (bus.count !== CNT_W'(3)) begin bad++; $display("FAIL midrst_pre: got %0d want 3", bus.count); end
        #1 reset = 1'b0;
        #2;
        total++; if (bus.count !== '0 || bus.data_valid !== 1'b0 || bus.data !== '0) begin bad++; $display("FAIL midrst_async: count=%0d valid=%b data=%h want 0 0 0", bus.count, bus.data_valid, bus.data); end
        #2 reset = 1'b1;
        push(256'hAAAAAAA);
        total++; if (bus.data !== 256'hAAAAAAA || bus.count !== CNT_W'(1)) begin bad++; $display("FAIL midrst_push: data=%h count=%0d want aaaaaaa 1", bus.data, bus.count); end
        pop();
        total++; if (bus.count !== '0 || bus.data_valid !== 1'b0) begin bad++; $display("FAIL midrst_drain: count=%0d valid=%b want 0 0", bus.count, bus.data_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_push();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
